// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one shift per clock).
// Define BIN2BCD_BLANK_EN to add the registered leading-zero blank mask.

module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       bcd, bcd_adj, result;
  logic [WIDTH-1:0]    bin;
  logic [CW-1:0]       cnt;
  logic [BW+WIDTH-1:0] shifted;
  logic                load, last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (.nib(bcd[4*g +: 4]), .adj(bcd_adj[4*g +: 4]));
  end

  // The top adjusted bit falls off the shift; it is always 0 for legal sizes.
  assign shifted = {bcd_adj, bin} << 1;
  assign result  = shifted[BW+WIDTH-1 -: BW];
  assign busy    = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE:  if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
             end
      SHIFT: if (cnt == CW'(1)) begin
               last      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bcd     <= '0;
      bin     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      state <= state_nxt;
      done  <= last;
      if (load) begin
        bcd <= '0;
        bin <= bin_in;
        cnt <= CW'(WIDTH);
      end else if (state == SHIFT) begin
        {bcd, bin} <= shifted;
        cnt        <= cnt - CW'(1);
      end
      if (last) bcd_out <= result;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              hi_zero;

  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      hi_zero      = hi_zero & (result[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (last) blank <= blank_nxt;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock. It sits directly upstream of the multiplexed 3-digit seven-segment driver. It turns a binary count into packed BCD digits, which the driver decodes and scans onto `uo_out`/`uio_out[7:5]`. The design is a start/busy/done handshake block with registered, held outputs.

## Interface
Parameters:
- `WIDTH`, default 8: binary input width; also the number of shift cycles.
- `DIGITS`, default 3: number of BCD digits. Legal only if 10^DIGITS > 2^WIDTH − 1; 8/3 covers 0–255.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `start`, input, 1: request a conversion; sampled only in IDLE.
- `bin_in`, input, WIDTH: binary value; captured on the accepting edge.
- `busy`, output, 1: high while a conversion is in progress (SHIFT state).
- `done`, output, 1: one-cycle pulse when `bcd_out` updates.
- `bcd_out`, output, 4*DIGITS: packed BCD; digit 0 (ones) is in `[3:0]`. Held between conversions.
- `blank`, output, DIGITS: leading-zero blank mask; see Configuration.

## Operation
- Internal state:
  - scratch register `{bcd[4*DIGITS-1:0], bin[WIDTH-1:0]}`;
  - cycle counter of width `$clog2(WIDTH+1)`;
  - two-state FSM: IDLE and SHIFT.
- IDLE:
  - `start`=1 loads `bin` ← `bin_in` and `bcd` ← 0, sets the counter to WIDTH, and moves to SHIFT.
  - `start`=0 stays in IDLE.
- SHIFT, each cycle:
  - Every scratch BCD nibble ≥ 5 gets +3; nibbles ≤ 4 are unchanged.
  - Then the whole scratch register shifts left by 1; bin MSB → bcd LSB, bin LSB ← 0.
  - The counter decrements.
- On the SHIFT cycle where the counter goes 1 → 0:
  - `bcd_out` is loaded with the shifted result;
  - `done` is set for one cycle;
  - the FSM returns to IDLE.
- `start` during SHIFT is ignored; it is not queued.
- `bin_in` changes after acceptance do not affect the conversion in progress.
- `bcd_out` and `blank` change only on the `done` edge. Between conversions they hold the last result.
- Every `bcd_out` nibble is always 0–9. Nibble arithmetic is 4-bit; the add-3 never overflows for legal parameters.

## Timing
- Reset: `rst_n`=0 at an edge forces:
  - FSM to IDLE;
  - `busy`=0, `done`=0;
  - `bcd_out`=0;
  - `blank`={DIGITS{1'b0}} with BIN2BCD_BLANK_EN off; otherwise the mask value for 0, e.g. 3'b110;
  - scratch register and counter cleared.
- Reset mid-conversion aborts it with no `done`; the old `bcd_out` is lost (it becomes 0).
- Acceptance: `start` sampled high at edge k in IDLE.
- `busy`: high after edge k, low after edge k+WIDTH; WIDTH cycles total (8 by default).
- Completion:
  - `bcd_out` is valid and `done`=1 in the cycle after edge k+WIDTH.
  - Latency is WIDTH edges from acceptance to result.
- Back-to-back: the next `start` is accepted at edge k+WIDTH+1, the same cycle `done` is high. With `start` held high, conversions issue every WIDTH+1 cycles.
- `done` never asserts for two consecutive cycles.

## Configuration
- Macro `BIN2BCD_BLANK_EN`.
- Defined:
  - `blank[i]`=1 for i ≥ 1 when digit i and every higher digit are 0.
  - `blank[0]` is always 0.
  - The mask is registered and updated on the same edge as `bcd_out`.
  - The display driver uses it to switch off leading zero digits.
- Undefined:
  - `blank` is tied to 0.
  - No mask logic is synthesized.

## Test plan
- `bin_in`=255, `start` pulse → `busy` high 8 cycles; then `done`=1 with `bcd_out`=12'h255; `blank`=3'b000.
- `bin_in`=0 → `bcd_out`=12'h000.
  - With BIN2BCD_BLANK_EN: `blank`=3'b110.
  - Without it: 3'b000.
- `bin_in`=9, then `bin_in`=100 → 12'h009 (blank 3'b110 when enabled), then 12'h100 (blank 3'b000).
- `start` held high, `bin_in` stepping 0..255 → one `done` every 9 cycles; each `bcd_out` matches the decimal of the value captured at acceptance.
- `start` re-pulsed and `bin_in` changed to 42 mid-conversion of 200 → result 12'h200; only one `done`; 42 not converted.
- `rst_n`=0 at cycle 4 of a conversion → next cycle `busy`=0 and `bcd_out`=0; no `done` pulse; a following `start` with 77 gives 12'h077.
